// File: rtl/mux_arbiter.sv
// Two-requester valid/ready arbiter feeding one registered output word.
// Round-robin with a burst limit by default; define MUX_ARB_FIXED_PRIO_EN for fixed in0 priority.
module mux_arbiter #(
  parameter int N         = 17,
  parameter int MAX_BURST = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in0_valid,
  input  logic [N-1:0] in0_data,
  output logic         in0_ready,
  input  logic         in1_valid,
  input  logic [N-1:0] in1_data,
  output logic         in1_ready,
  output logic         out_valid,
  output logic [N-1:0] out_data,
  input  logic         out_ready,
  output logic         choose
);

  localparam int CW = $clog2(MAX_BURST + 1);
  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_BURST);

  logic          cur_r;
  logic [CW-1:0] burst_cnt_r;
  logic          accept_s;
  logic          sel_s;
  logic          sel_valid_s;
  logic          grant_s;

  assign accept_s = !out_valid || out_ready;

  // Winner selection for this cycle
  always_comb begin
    sel_s = cur_r;
`ifdef MUX_ARB_FIXED_PRIO_EN
    if (in0_valid) begin
      sel_s = 1'b0;
    end else begin
      sel_s = 1'b1;
    end
`else
    if (in0_valid && in1_valid) begin
      // The owner keeps the datapath until its burst budget is spent
      if (burst_cnt_r < MAX_CNT) begin
        sel_s = cur_r;
      end else begin
        sel_s = !cur_r;
      end
    end else if (in0_valid) begin
      sel_s = 1'b0;
    end else if (in1_valid) begin
      sel_s = 1'b1;
    end else begin
      sel_s = cur_r;
    end
`endif
  end

  // Grant qualification and upstream readies
  always_comb begin
    sel_valid_s = 1'b0;
    if (sel_s) begin
      sel_valid_s = in1_valid;
    end else begin
      sel_valid_s = in0_valid;
    end
    grant_s   = accept_s && sel_valid_s;
    in0_ready = accept_s && (sel_s == 1'b0);
    in1_ready = accept_s && (sel_s == 1'b1);
  end

  // Output register, owner and burst counter
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid   <= 1'b0;
      out_data    <= '0;
      choose      <= 1'b0;
      cur_r       <= 1'b0;
      burst_cnt_r <= '0;
    end else if (grant_s) begin
      out_valid <= 1'b1;
      choose    <= sel_s;
      if (sel_s) begin
        out_data <= in1_data;
      end else begin
        out_data <= in0_data;
      end
`ifdef MUX_ARB_FIXED_PRIO_EN
      cur_r       <= sel_s;
      burst_cnt_r <= '0;
`else
      if (sel_s == cur_r) begin
        if (burst_cnt_r >= MAX_CNT) begin
          burst_cnt_r <= MAX_CNT;
        end else begin
          burst_cnt_r <= burst_cnt_r + CW'(1);
        end
      end else begin
        cur_r       <= sel_s;
        burst_cnt_r <= CW'(1);
      end
`endif
    end else if (accept_s) begin
      // Idle accepted cycle: output drains and the burst is closed
      out_valid   <= 1'b0;
      burst_cnt_r <= '0;
    end else begin
      out_valid   <= out_valid;
      burst_cnt_r <= burst_cnt_r;
    end
  end

endmodule

// File: tb/tb_mux_arbiter.sv
// Directed bench for mux_arbiter (MAX_BURST=2); fixed-priority vectors apply
// when MUX_ARB_FIXED_PRIO_EN is defined, round-robin vectors otherwise.
module tb_mux_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        in0_valid, in1_valid, out_ready;
  logic [16:0] in0_data, in1_data;
  logic        in0_ready, in1_ready, out_valid, choose;
  logic [16:0] out_data;

  int n_vec = 0;
  int n_err = 0;

  mux_arbiter #(.N(17), .MAX_BURST(2)) dut (
    .clk(clk), .rst(rst),
    .in0_valid(in0_valid), .in0_data(in0_data), .in0_ready(in0_ready),
    .in1_valid(in1_valid), .in1_data(in1_data), .in1_ready(in1_ready),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .choose(choose)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v0, input logic [16:0] d0, input logic v1,
                       input logic [16:0] d1, input logic ordy);
    in0_valid = v0; in0_data = d0;
    in1_valid = v1; in1_data = d1;
    out_ready = ordy;
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    int exp2 [6] = '{0, 0, 1, 1, 0, 0};
    int exp3 [3] = '{1, 1, 0};
    rst = 1'b1;
    drive(1'b0, 17'h0, 1'b0, 17'h0, 1'b1);
    do_reset();
    check("rst_valid", out_valid, 32'd0);
    check("rst_data", out_data, 32'd0);
    check("rst_choose", choose, 32'd0);
    check("rst_rdy0", in0_ready, 32'd1);
    check("rst_rdy1", in1_ready, 32'd0);

`ifndef MUX_ARB_FIXED_PRIO_EN
    // single word from in0
    drive(1'b1, 17'h00001, 1'b0, 17'h0, 1'b1);
    check("t1_rdy1", in1_ready, 32'd0);
    tick();
    check("t1_valid", out_valid, 32'd1);
    check("t1_data", out_data, 32'h1);
    check("t1_choose", choose, 32'd0);
    drive(1'b0, 17'h0, 1'b0, 17'h0, 1'b1);
    check("t1_rdy1_idle", in1_ready, 32'd0);
    tick();
    check("t1_drain", out_valid, 32'd0);
    check("t1_hold", out_data, 32'h1);

    // both valid, burst limit 2: in0 in0 in1 in1 in0 in0
    for (int k = 0; k < 6; k++) begin
      drive(1'b1, 17'h100 + 17'(k), 1'b1, 17'h200 + 17'(k), 1'b1);
      check("t2_rdy0", in0_ready, (exp2[k] == 0) ? 32'd1 : 32'd0);
      check("t2_rdy1", in1_ready, (exp2[k] == 1) ? 32'd1 : 32'd0);
      tick();
      check("t2_data", out_data, (exp2[k] == 1) ? 32'h200 + 32'(k) : 32'h100 + 32'(k));
      check("t2_choose", choose, 32'(exp2[k]));
    end

    // stall: output frozen, no readies
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 17'h180 + 17'(k), 1'b1, 17'h280 + 17'(k), 1'b0);
      check("t3_rdy0", in0_ready, 32'd0);
      check("t3_rdy1", in1_ready, 32'd0);
      tick();
      check("t3_valid", out_valid, 32'd1);
      check("t3_data", out_data, 32'h105);
      check("t3_choose", choose, 32'd0);
    end
    // release: in0 burst was spent, so in1 takes two, then in0
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 17'h110 + 17'(k), 1'b1, 17'h210 + 17'(k), 1'b1);
      tick();
      check("t3_rel_data", out_data, (exp3[k] == 1) ? 32'h210 + 32'(k) : 32'h110 + 32'(k));
      check("t3_rel_choose", choose, 32'(exp3[k]));
    end

    // reset with a word held and burst count 1
    drive(1'b1, 17'h1AAAA, 1'b1, 17'h15555, 1'b1);
    do_reset();
    drive(1'b0, 17'h0, 1'b0, 17'h0, 1'b1);
    check("t5_valid", out_valid, 32'd0);
    check("t5_data", out_data, 32'd0);
    check("t5_choose", choose, 32'd0);
    check("t5_rdy0", in0_ready, 32'd1);
    check("t5_rdy1", in1_ready, 32'd0);

    // only in1: wins every cycle, count saturates at 2
    for (int k = 0; k < 5; k++) begin
      drive(1'b0, 17'h0, 1'b1, 17'h300 + 17'(k), 1'b1);
      check("t4_rdy1", in1_ready, 32'd1);
      check("t4_rdy0", in0_ready, 32'd0);
      tick();
      check("t4_data", out_data, 32'h300 + 32'(k));
      check("t4_choose", choose, 32'd1);
    end
    drive(1'b1, 17'h0ABC, 1'b1, 17'h0DEF, 1'b1);
    check("t4_sw_rdy0", in0_ready, 32'd1);
    tick();
    check("t4_sw_data", out_data, 32'h0ABC);
    check("t4_sw_choose", choose, 32'd0);
`else
    // fixed priority: in0 always wins while valid
    for (int k = 0; k < 5; k++) begin
      drive(1'b1, 17'h400 + 17'(k), 1'b1, 17'h500 + 17'(k), 1'b1);
      check("t6_rdy0", in0_ready, 32'd1);
      check("t6_rdy1", in1_ready, 32'd0);
      tick();
      check("t6_data", out_data, 32'h400 + 32'(k));
      check("t6_choose", choose, 32'd0);
    end
    drive(1'b0, 17'h0, 1'b1, 17'h555, 1'b1);
    check("t6_drop_rdy1", in1_ready, 32'd1);
    tick();
    check("t6_drop_data", out_data, 32'h555);
    check("t6_drop_choose", choose, 32'd1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
